// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
package mem_pkg;

  localparam int WORD_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mem_req_t;

  // Byte address to doubleword index; the low bits are checked separately for alignment.
  function automatic logic [60:0] addr_to_index(input logic [63:0] addr);
    return addr[63:$clog2(WORD_BYTES)];
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the load/store stage and data memory.
interface data_mem_responder_if #(
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [63:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/mem_word_array.sv
// DEPTH x DATA_W register array: synchronous clear and write, asynchronous indexed read.
module mem_word_array #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 64,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] word_reg [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      always_ff @(posedge clk) begin
        if (clr) begin
          word_reg[gi] <= '0;
        end else if (we && (widx == IDX_W'(gi))) begin
          word_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  assign rdata = word_reg[ridx];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts one load/store, waits LATENCY cycles, then returns a held response.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2,
  parameter int DATA_W  = 64
) (
  input logic                 clk,
  input logic                 reset_n,
  data_mem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  mem_req_t          req_reg, req_next;
  logic              req_ready_reg, req_ready_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic              rsp_error_reg, rsp_error_next;

  mem_req_t          cur_req;
  logic              accept;
  logic              commit;
  logic [60:0]       word_idx;
  logic              access_err;
  logic              mem_we;
  logic [DATA_W-1:0] rd_word;

  // With LATENCY=1 the accept edge is also the commit edge, so use the live inputs there.
  assign cur_req    = (state_reg == IDLE) ? {bus.req_write, bus.req_addr, bus.req_wdata} : req_reg;
  assign accept     = (state_reg == IDLE) && req_ready_reg && bus.req_valid;
  assign commit     = ((LATENCY == 1) && accept) || ((state_reg == WAIT) && (cnt_reg == 4'd1));
  assign word_idx   = addr_to_index(cur_req.addr);
  assign access_err = (cur_req.addr[2:0] != 3'd0) || (word_idx >= 61'(DEPTH));
  assign mem_we     = commit && cur_req.write && !access_err;

  mem_word_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .clr   (!reset_n),
    .we    (mem_we),
    .widx  (word_idx[IDX_W-1:0]),
    .wdata (cur_req.wdata),
    .ridx  (word_idx[IDX_W-1:0]),
    .rdata (rd_word)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    req_next       = req_reg;
    req_ready_next = req_ready_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_error_next = rsp_error_reg;

    case (state_reg)
      IDLE: begin
        // req_ready lags the return to IDLE by one cycle, giving LATENCY+2 cycles per transaction.
        req_ready_next = 1'b1;
        if (accept) begin
          req_next       = cur_req;
          req_ready_next = 1'b0;
          state_next     = WAIT;
          cnt_next       = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_reg != 4'd1) begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
          rsp_rdata_next = '0;
          rsp_error_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    if (commit) begin
      state_next     = RESP;
      cnt_next       = 4'd0;
      rsp_valid_next = 1'b1;
      rsp_error_next = access_err;
      rsp_rdata_next = (cur_req.write || access_err) ? '0 : rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      req_reg       <= '0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      req_reg       <= req_next;
      req_ready_reg <= req_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_error_reg <= rsp_error_next;
    end
  end

  assign bus.req_ready = req_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_error = rsp_error_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized checks of data_mem_responder against an array-based memory model.
module tb_data_mem_responder;

  localparam int DEPTH = 32;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if #(.DATA_W(64)) bus0 ();
  data_mem_responder_if #(.DATA_W(64)) bus1 ();

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .DATA_W(64)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0.slave)
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1), .DATA_W(64)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] model_mem [DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference: a plain word array; errors never touch it and return zero data.
  function automatic void model_access(input bit w, input logic [63:0] a, input logic [63:0] d,
                                       output logic [63:0] rd, output bit er);
    logic [63:0] idx;
    idx = a / 8;
    er = (a % 8 != 0) || (idx >= 64'(DEPTH));
    rd = '0;
    if (!er) begin
      if (w) model_mem[int'(idx)] = d;
      else   rd = model_mem[int'(idx)];
    end
  endfunction

  // Called at a negedge; returns at a negedge one cycle after the response handshake.
  task automatic txn(input string tag, input bit w, input logic [63:0] a, input logic [63:0] d,
                     input int hold);
    logic [63:0] exp_rd, got_rd;
    bit          exp_er;
    logic        got_er;
    int          k;
    model_access(w, a, d, exp_rd, exp_er);
    bus0.req_valid = 1'b1;
    bus0.req_write = w;
    bus0.req_addr  = a;
    bus0.req_wdata = d;
    k = 0;
    while (!bus0.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, " req_ready"}, 64'(bus0.req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    bus0.req_write = 1'($urandom);
    bus0.req_addr  = {$urandom, $urandom};
    bus0.req_wdata = {$urandom, $urandom};
    k = 1;
    while (!bus0.rsp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 64'(k), 64'(LAT));
    got_rd = bus0.rsp_rdata;
    got_er = bus0.rsp_error;
    check({tag, " rdata"}, got_rd, exp_rd);
    check({tag, " error"}, 64'(got_er), 64'(exp_er));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold valid"}, 64'(bus0.rsp_valid), 64'd1);
      check({tag, " hold rdata"}, bus0.rsp_rdata, got_rd);
      check({tag, " hold ready"}, 64'(bus0.req_ready), 64'd0);
    end
    bus0.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.rsp_ready = 1'b0;
    check({tag, " post valid"}, 64'(bus0.rsp_valid), 64'd0);
    check({tag, " post rdata"}, bus0.rsp_rdata, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, cmp;
    bit prev_a, a_now;
    logic [63:0] addr;

    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    bus0.req_valid = 0; bus0.req_write = 0; bus0.req_addr = 0; bus0.req_wdata = 0; bus0.rsp_ready = 0;
    bus1.req_valid = 0; bus1.req_write = 0; bus1.req_addr = 0; bus1.req_wdata = 0; bus1.rsp_ready = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("reset req_ready", 64'(bus0.req_ready), 64'd1);
    check("reset rsp_valid", 64'(bus0.rsp_valid), 64'd0);
    check("reset rsp_rdata", bus0.rsp_rdata, 64'd0);
    check("reset rsp_error", 64'(bus0.rsp_error), 64'd0);
    check("reset lat1 req_ready", 64'(bus1.req_ready), 64'd1);

    txn("store10", 1'b1, 64'h10, 64'h0123_4567_89AB_CDEF, 0);
    txn("load10", 1'b0, 64'h10, 64'h0, 0);
    txn("load10 held", 1'b0, 64'h10, 64'h0, 5);
    txn("store misaligned", 1'b1, 64'h0C, 64'hDEAD_BEEF_0000_0001, 1);
    txn("store out of range", 1'b1, 64'h100, 64'hDEAD_BEEF_0000_0002, 0);
    txn("load08", 1'b0, 64'h08, 64'h0, 0);
    txn("load last", 1'b0, 64'(8 * DEPTH - 8), 64'h0, 0);

    // Reset while the store is still waiting to commit.
    bus0.req_valid = 1'b1;
    bus0.req_write = 1'b1;
    bus0.req_addr  = 64'h18;
    bus0.req_wdata = 64'hFFFF;
    while (!bus0.req_ready) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    check("abort req_ready", 64'(bus0.req_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("abort no rsp", 64'(bus0.rsp_valid), 64'd0);
      @(negedge clk);
    end
    txn("load18 after abort", 1'b0, 64'h18, 64'h0, 0);

    for (int n = 0; n < 30; n++) begin
      addr = 64'($urandom_range(0, DEPTH + 3)) * 8;
      if ($urandom_range(0, 7) == 0) addr = addr + 64'($urandom_range(1, 7));
      txn("random", 1'($urandom_range(0, 1)), addr, {$urandom, $urandom}, $urandom_range(0, 3));
    end

    // LATENCY=1 instance streaming with both valids held high.
    bus1.req_valid = 1'b1;
    bus1.req_write = 1'b1;
    bus1.req_addr  = 64'h20;
    bus1.req_wdata = 64'hAA;
    bus1.rsp_ready = 1'b1;
    acc = 0;
    cmp = 0;
    prev_a = 1'b0;
    for (int c = 0; c < 9; c++) begin
      a_now = bus1.req_ready && bus1.req_valid;
      if (a_now) acc++;
      if (bus1.rsp_valid) begin
        cmp++;
        check("lat1 valid after accept", 64'(prev_a), 64'd1);
        check("lat1 store rdata", bus1.rsp_rdata, 64'd0);
      end
      prev_a = a_now;
      @(negedge clk);
    end
    bus1.req_valid = 1'b0;
    bus1.rsp_ready = 1'b0;
    check("lat1 accepts", 64'(acc), 64'd3);
    check("lat1 completions", 64'(cmp), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (memory side) for the processor's data-memory port: accepts one load/store request at a time over a valid/ready handshake.
- Waits a fixed access latency, then returns a response over a second valid/ready handshake.
- Holds DEPTH 64-bit doublewords addressed by byte address.
- Replaces the combinational DataMemory in the multi-cycle core; the core's load/store stage is the initiator.

Parameters:
- DEPTH, 32, number of 64-bit words stored; legal addresses are 0 .. 8*DEPTH-8.
- LATENCY, 2, cycles from request-accept edge to first rsp_valid cycle; legal range 1..15.
- DATA_W, 64, data width; fixed at 64, parameterised only for documentation.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- req_valid  in  1  initiator presents a request
- req_ready  out  1  responder can accept (IDLE only)
- req_write  in  1  1 = store, 0 = load
- req_addr  in  64  byte address
- req_wdata  in  64  store data
- rsp_valid  out  1  response available
- rsp_ready  in  1  initiator takes response
- rsp_rdata  out  64  load data; 0 for stores and errors
- rsp_error  out  1  misaligned or out-of-range access

Behaviour:
- Reset (reset_n=0 at a rising edge) does the following:
  - state=IDLE, req_ready=1 from the next cycle, rsp_valid=0, rsp_rdata=0, rsp_error=0, latency counter=0.
  - All DEPTH words are cleared to 0.
- Reset mid-transaction aborts the transaction: a pending store that has not yet committed is dropped, and no response is issued.
- States are IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - Accept occurs on an edge where req_valid=1; capture write, addr and wdata.
  - If LATENCY=1, go to RESP; otherwise go to WAIT with counter=LATENCY-1.
- WAIT:
  - req_ready=0.
  - Counter decrements each edge; when it reaches 1, go to RESP on that edge.
- Entering RESP is the commit edge:
  - A legal store writes mem[addr[63:3]] and returns rsp_rdata=0.
  - A legal load returns rsp_rdata=mem[addr[63:3]].
  - Result: rsp_valid rises exactly LATENCY cycles after the accept edge.
- Error rule: rsp_error=1 if addr[2:0]!=0 or addr[63:3]>=DEPTH.
  - An error store does not modify memory.
  - An error access returns rsp_rdata=0.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_error are held stable until an edge with rsp_ready=1.
  - On that edge, go to IDLE and clear rsp_valid, rsp_rdata and rsp_error.
  - req_ready=0 throughout RESP; there is no same-cycle re-accept, so back-to-back throughput is one transaction per LATENCY+2 cycles minimum.
- Inputs are sampled only at the accept edge; changes to req_* after accept are ignored.
- rsp_ready asserted while not in RESP is ignored.
- A load to the same word as the immediately preceding store returns the stored value (commit precedes any later accept).
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP) as a 2-bit typedef;
  - localparam WORD_BYTES=8;
  - an address-to-index helper function;
  - the request struct {write, addr, wdata}.
- One sub-module, mem_word_array: DEPTH×64 register array with synchronous write enable, synchronous clear and asynchronous read by index.
- FSM, counter and error check stay in data_mem_responder.

Test Plan:
- Reset then idle, with LATENCY=2 → req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0.
- Store 0x0123_4567_89AB_CDEF to addr 0x10, then load addr 0x10 with rsp_ready=1 → each rsp_valid rises exactly 2 cycles after its accept edge; the load returns 0x0123_4567_89AB_CDEF with rsp_error=0; the store returns rdata=0.
- Load addr 0x10 with rsp_ready=0 for 5 cycles, then 1 → rsp_valid and rdata stay stable for all 6 cycles; req_ready=0 until the cycle after the handshake.
- Store to addr 0x0C (misaligned), then to 0x100 (out of range with DEPTH=32), then load 0x08 → the first two return rsp_error=1 and rdata=0; the load returns 0, showing memory is untouched.
- Accept a store of 0xFFFF to addr 0x18, then pull reset_n=0 in the WAIT cycle; after reset, load 0x18 → returns 0 and no stale response appears.
- Run with LATENCY=1, holding req_valid=1 and rsp_ready=1 continuously for 9 cycles → exactly 3 transactions complete, with rsp_valid one cycle after each accept.
